// File: rtl/servo_pkg.sv
// servo_pkg: shared constants, types and position-to-width mapping for servo_pwm
package servo_pkg;
  localparam int CLK_HZ_DEFAULT = 25_000_000;
  localparam int SERVO_MIN_US   = 1000;
  localparam int SERVO_MAX_US   = 2000;
  localparam int SERVO_FRAME_US = 20000;
  localparam int SERVO_STEP_US  = 10;
  typedef logic [14:0] pulse_us_t;
  typedef logic [7:0] servo_pos_t;
  typedef enum logic {SLOT_EMPTY, SLOT_FULL} slot_e;
  function automatic pulse_us_t pos_to_us(servo_pos_t pos, int min_us, int max_us);
    return pulse_us_t'(min_us + int'(pos) * (max_us - min_us) / 255);
  endfunction
endpackage

// File: rtl/servo_pwm_if.sv
// servo_pwm_if: position command valid/ready handshake
interface servo_pwm_if;
  import servo_pkg::*;
  servo_pos_t cmd_pos;
  logic cmd_valid;
  logic cmd_ready;
  modport master (output cmd_pos, output cmd_valid, input cmd_ready);
  modport slave (input cmd_pos, input cmd_valid, output cmd_ready);
endinterface

// File: rtl/servo_pwm_us_tick.sv
// us_tick: microsecond prescaler; tick_o on the terminal count, zero_o on the first cycle of each us
module us_tick #(
  parameter int DIV = 25
) (
  input  logic clk,
  input  logic rst,
  output logic tick_o,
  output logic zero_o
);
  localparam int W = $clog2(DIV);
  logic [W-1:0] cnt_q;
  assign tick_o = cnt_q == W'(DIV - 1);
  assign zero_o = cnt_q == '0;
  always_ff @(posedge clk)
    if (rst) cnt_q <= '0;
    else cnt_q <= tick_o ? '0 : cnt_q + 1'b1;
endmodule

// File: rtl/servo_pwm.sv
// servo_pwm: 50 Hz servo PWM with one-entry command slot and per-frame slew limiting
module servo_pwm
  import servo_pkg::*;
#(
  parameter int CLK_HZ   = CLK_HZ_DEFAULT,
  parameter int FRAME_US = SERVO_FRAME_US,
  parameter int MIN_US   = SERVO_MIN_US,
  parameter int MAX_US   = SERVO_MAX_US,
  parameter int STEP_US  = SERVO_STEP_US
) (
  input  logic        clk,
  input  logic        rst,
  servo_pwm_if.slave  cmd,
  output logic        servo_pin,
  output logic        frame_start,
  output logic        at_target,
  output logic        led_verde,
  output logic        led_verm
);
  localparam pulse_us_t STEP = pulse_us_t'(STEP_US);
  localparam pulse_us_t MID  = pulse_us_t'((MIN_US + MAX_US) / 2);
  localparam pulse_us_t LAST = pulse_us_t'(FRAME_US - 1);
  logic tick, us0, acc, bnd, up;
  pulse_us_t fus_q, fus_d, tgt_q, tgt_d, cur_q, cur_d, gap;
  servo_pos_t pend_q, pend_d;
  slot_e slot_q, slot_d;
  us_tick #(.DIV(CLK_HZ / 1_000_000)) u_tick (.clk(clk), .rst(rst), .tick_o(tick), .zero_o(us0));
  assign cmd.cmd_ready = (slot_q == SLOT_EMPTY) & ~rst;
  assign acc = cmd.cmd_valid & cmd.cmd_ready;
  assign bnd = us0 && fus_q == '0;
  assign led_verde = at_target;
  assign led_verm = ~at_target;
  // a command accepted on the boundary edge itself goes straight to target
  always_comb begin
    fus_d = tick ? (fus_q == LAST ? '0 : fus_q + 1'b1) : fus_q;
    tgt_d = !bnd ? tgt_q
          : slot_q == SLOT_FULL ? pos_to_us(pend_q, MIN_US, MAX_US)
          : acc ? pos_to_us(cmd.cmd_pos, MIN_US, MAX_US) : tgt_q;
    slot_d = bnd ? SLOT_EMPTY : acc ? SLOT_FULL : slot_q;
    pend_d = acc ? cmd.cmd_pos : pend_q;
    up = tgt_d > cur_q;
    gap = up ? tgt_d - cur_q : cur_q - tgt_d;
    cur_d = !bnd ? cur_q : gap <= STEP ? tgt_d : up ? cur_q + STEP : cur_q - STEP;
  end
  always_ff @(posedge clk)
    if (rst) begin
      fus_q <= '0;
      tgt_q <= MID;
      cur_q <= MID;
      pend_q <= '0;
      slot_q <= SLOT_EMPTY;
      servo_pin <= 1'b0;
      frame_start <= 1'b0;
      at_target <= 1'b1;
    end else begin
      fus_q <= fus_d;
      tgt_q <= tgt_d;
      cur_q <= cur_d;
      pend_q <= pend_d;
      slot_q <= slot_d;
      servo_pin <= fus_q < cur_d;
      frame_start <= bnd;
      at_target <= cur_d == tgt_d && slot_d == SLOT_EMPTY;
    end
endmodule

// File: tb/tb_servo_pwm.sv
// tb_servo_pwm: randomized commands against a frame-level servo model with a pulse-width scoreboard
module tb_servo_pwm;
  import servo_pkg::*;
  localparam int DIV = 2, FRAME_US = 100, MIN_US = 8, MAX_US = 89, STEP_US = 3;
  localparam int FC = DIV * FRAME_US, MID = (MIN_US + MAX_US) / 2;
  typedef struct {int e; int pos;} cmd_t;
  logic clk = 0, rst = 1;
  logic servo_pin, frame_start, at_target, led_verde, led_verm;
  servo_pwm_if cmd_if();
  servo_pwm #(.CLK_HZ(DIV * 1_000_000), .FRAME_US(FRAME_US), .MIN_US(MIN_US), .MAX_US(MAX_US),
              .STEP_US(STEP_US)) dut (
    .clk(clk), .rst(rst), .cmd(cmd_if), .servo_pin(servo_pin), .frame_start(frame_start),
    .at_target(at_target), .led_verde(led_verde), .led_verm(led_verm));
  always #5 clk = ~clk;
  int n_vec = 0, n_err = 0, ecnt = 0, tgt = MID, cur = MID;
  bit rst_s = 1;
  cmd_t cmd_q[$];
  int exp_q[$];
  task automatic check(input string name, input int got, input int want);
    n_vec++;
    if (got != want) begin
      n_err++;
      $display("FAIL %s at edge %0d: got %0d, expected %0d", name, ecnt, got, want);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  // edges since reset release; edge 1 registers the first cycle of frame 0
  initial forever begin
    @(posedge clk);
    rst_s = rst;
    ecnt = rst ? 0 : ecnt + 1;
  end
  initial forever begin
    bit pend, at, bnd;
    @(negedge clk);
    bnd = !rst_s && (ecnt - 1) % FC == 0;
    if (rst_s) begin
      tgt = MID;
      cur = MID;
      cmd_q.delete();
      exp_q.delete();
      check("rst_servo_pin", int'(servo_pin), 0);
    end else if (bnd) begin
      if (cmd_q.size() > 0 && cmd_q[0].e <= ecnt) begin
        tgt = MIN_US + cmd_q[0].pos * (MAX_US - MIN_US) / 255;
        void'(cmd_q.pop_front());
      end
      if (tgt - cur > STEP_US) cur += STEP_US;
      else if (cur - tgt > STEP_US) cur -= STEP_US;
      else cur = tgt;
      exp_q.push_back(cur);
    end
    pend = cmd_q.size() > 0 && cmd_q[0].e <= ecnt;
    at = cur == tgt && !pend;
    check("frame_start", int'(frame_start), int'(bnd));
    check("cmd_ready", int'(cmd_if.cmd_ready), int'(!rst && !pend));
    check("at_target", int'(at_target), int'(at));
    check("led_verde", int'(led_verde), int'(at));
    check("led_verm", int'(led_verm), int'(!at));
  end
  initial begin
    int hi = 0, len = 0, w;
    bit act = 0;
    forever begin
      @(negedge clk);
      if (rst_s) act = 0;
      else begin
        if (frame_start) begin
          if (act) begin
            if (exp_q.size() == 0) check("frame_expected", 0, 1);
            else begin
              w = exp_q.pop_front();
              check("pulse_cycles", hi, w * DIV);
              check("frame_cycles", len, FC);
            end
          end
          hi = 0;
          len = 0;
          act = 1;
        end
        if (act) begin
          len++;
          hi += int'(servo_pin);
        end
      end
    end
  end
  task automatic send(input int p);
    int n = 0;
    cmd_if.cmd_valid = 1;
    cmd_if.cmd_pos = 8'(p);
    while (!cmd_if.cmd_ready && n <= 2 * FC) begin
      step();
      n++;
    end
    check("handshake_in_time", int'(n <= 2 * FC), 1);
    if (n <= 2 * FC) begin
      cmd_q.push_back('{ecnt + 1, p});
      step();
    end
    cmd_if.cmd_valid = 0;
  endtask
  task automatic wait_last();
    while (ecnt % FC != 0) step();
  endtask
  initial begin
    cmd_if.cmd_valid = 0;
    cmd_if.cmd_pos = 0;
    repeat (4) step();
    rst = 0;
    repeat (3 * FC) step();
    repeat (57) step();
    send(255);
    repeat (30 * FC) step();
    send(0);
    send(128);
    repeat (3 * FC) step();
    wait_last();
    send(200);
    repeat (FC / 2) step();
    send(40);
    wait_last();
    send(230);
    repeat (2 * FC) step();
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 300)) step();
      send(int'($urandom_range(0, 255)));
    end
    send(255);
    repeat (30 * FC) step();
    while (ecnt % FC != 100) step();
    check("pin_before_rst", int'(servo_pin), 1);
    rst = 1;
    step();
    rst = 0;
    repeat (3 * FC) step();
    check("exp_q_depth", exp_q.size(), 1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
